// File: rtl/iso_pkg.sv
// Shared constants for the ISO block: DisplayPort K-codes, the idle VB-ID value
// and the slot positions at the start of each idle-pattern period.
package iso_pkg;

   localparam logic [7:0] K_BS      = 8'hBC;
   localparam logic [7:0] K_SR      = 8'h1C;
   localparam logic [7:0] VBID_IDLE = 8'h09;

   localparam int unsigned SLOT_BS   = 32'd0;
   localparam int unsigned SLOT_VBID = 32'd1;
   localparam int unsigned SLOT_MVID = 32'd2;
   localparam int unsigned SLOT_MAUD = 32'd3;

endpackage

// File: rtl/idle_pattern_gen.sv
// DisplayPort idle-pattern generator for one lane: BS/SR, VB-ID, Mvid, Maud,
// then dummy data, repeating every PERIOD symbols with SR every SR_INTERVAL periods.
module idle_pattern_gen
   import iso_pkg::*;
#(
   parameter int          PERIOD      = 8192,
   parameter int          SR_INTERVAL = 512,
   parameter logic [7:0]  DUMMY_SYM   = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       idle_en,
   input  logic [7:0] mvid_lsb,
   input  logic [7:0] maud_lsb,
   output logic [7:0] idle_symbols,
   output logic       idle_control_sym_flag,
   output logic       idle_bs_pulse,
   output logic       idle_sr_pulse
);

   localparam int SYM_W = $clog2(PERIOD);
   localparam int BS_W  = (SR_INTERVAL > 1) ? $clog2(SR_INTERVAL) : 1;
   localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(PERIOD - 1);
   localparam logic [BS_W-1:0]  BS_LAST  = BS_W'(SR_INTERVAL - 1);

   logic [SYM_W-1:0] sym_cnt_r;
   logic [BS_W-1:0]  bs_cnt_r;
   logic [SYM_W-1:0] sym_cnt_nxt_s;
   logic [BS_W-1:0]  bs_cnt_nxt_s;
   logic [7:0]       sel_sym_s;
   logic             sel_flag_s;
   logic             sel_bs_s;
   logic             sel_sr_s;

   // Symbol, K-flag and pulses for the slot addressed by the current counters.
   always_comb begin
      sel_sym_s  = DUMMY_SYM;
      sel_flag_s = 1'b0;
      sel_bs_s   = 1'b0;
      sel_sr_s   = 1'b0;
      case (sym_cnt_r)
         SYM_W'(SLOT_BS): begin
            sel_flag_s = 1'b1;
            sel_bs_s   = 1'b1;
            if (bs_cnt_r == {BS_W{1'b0}}) begin
               sel_sym_s = K_SR;
               sel_sr_s  = 1'b1;
            end else begin
               sel_sym_s = K_BS;
               sel_sr_s  = 1'b0;
            end
         end
         SYM_W'(SLOT_VBID): sel_sym_s = VBID_IDLE;
         SYM_W'(SLOT_MVID): sel_sym_s = mvid_lsb;
         SYM_W'(SLOT_MAUD): sel_sym_s = maud_lsb;
         default:           sel_sym_s = DUMMY_SYM;
      endcase
   end

   // Counter advance: period position wraps at PERIOD-1 and bumps the SR interval count.
   always_comb begin
      sym_cnt_nxt_s = sym_cnt_r + SYM_W'(1);
      bs_cnt_nxt_s  = bs_cnt_r;
      if (sym_cnt_r == SYM_LAST) begin
         sym_cnt_nxt_s = {SYM_W{1'b0}};
         if (bs_cnt_r == BS_LAST) begin
            bs_cnt_nxt_s = {BS_W{1'b0}};
         end else begin
            bs_cnt_nxt_s = bs_cnt_r + BS_W'(1);
         end
      end else begin
         sym_cnt_nxt_s = sym_cnt_r + SYM_W'(1);
      end
   end

   // Registered outputs and counters; dropping idle_en aborts the period so the next start is SR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sym_cnt_r             <= {SYM_W{1'b0}};
         bs_cnt_r              <= {BS_W{1'b0}};
         idle_symbols          <= 8'h00;
         idle_control_sym_flag <= 1'b0;
         idle_bs_pulse         <= 1'b0;
         idle_sr_pulse         <= 1'b0;
      end else if (!idle_en) begin
         sym_cnt_r             <= {SYM_W{1'b0}};
         bs_cnt_r              <= {BS_W{1'b0}};
         idle_symbols          <= DUMMY_SYM;
         idle_control_sym_flag <= 1'b0;
         idle_bs_pulse         <= 1'b0;
         idle_sr_pulse         <= 1'b0;
      end else begin
         sym_cnt_r             <= sym_cnt_nxt_s;
         bs_cnt_r              <= bs_cnt_nxt_s;
         idle_symbols          <= sel_sym_s;
         idle_control_sym_flag <= sel_flag_s;
         idle_bs_pulse         <= sel_bs_s;
         idle_sr_pulse         <= sel_sr_s;
      end
   end

endmodule

// File: tb/tb_idle_pattern_gen.sv
// Bench for idle_pattern_gen: two instances (PERIOD=16/SR_INTERVAL=4 and PERIOD=5/SR_INTERVAL=1)
// checked every cycle against an arithmetic model, plus hand-computed literal expectations.
module tb_idle_pattern_gen;

   logic       clk;
   logic       rst_n;
   logic       idle_en;
   logic [7:0] mvid_lsb;
   logic [7:0] maud_lsb;

   logic [7:0] sym_a, sym_b;
   logic       flag_a, flag_b, bs_a, bs_b, sr_a, sr_b;

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   // Model state: symbols since enable, and expected {sym, flag, bs, sr}.
   int          k_a, k_b;
   logic [10:0] exp_a, exp_b;

   idle_pattern_gen #(.PERIOD(16), .SR_INTERVAL(4), .DUMMY_SYM(8'h00)) dut_a (
      .clk(clk), .rst_n(rst_n), .idle_en(idle_en),
      .mvid_lsb(mvid_lsb), .maud_lsb(maud_lsb),
      .idle_symbols(sym_a), .idle_control_sym_flag(flag_a),
      .idle_bs_pulse(bs_a), .idle_sr_pulse(sr_a)
   );

   idle_pattern_gen #(.PERIOD(5), .SR_INTERVAL(1), .DUMMY_SYM(8'h00)) dut_b (
      .clk(clk), .rst_n(rst_n), .idle_en(idle_en),
      .mvid_lsb(mvid_lsb), .maud_lsb(maud_lsb),
      .idle_symbols(sym_b), .idle_control_sym_flag(flag_b),
      .idle_bs_pulse(bs_b), .idle_sr_pulse(sr_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs for the k-th symbol since enable: position in period and period number.
   function automatic logic [10:0] model_out(int k, int per, int sri,
                                             logic [7:0] mv, logic [7:0] ma);
      int  pos;
      int  n;
      logic is_sr;
      pos   = k % per;
      n     = k / per;
      is_sr = ((n % sri) == 0);
      case (pos)
         0:       return {(is_sr ? 8'h1C : 8'hBC), 1'b1, 1'b1, is_sr};
         1:       return {8'h09, 3'b000};
         2:       return {mv, 3'b000};
         3:       return {ma, 3'b000};
         default: return {8'h00, 3'b000};
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_a <= 0; k_b <= 0;
         exp_a <= 11'd0; exp_b <= 11'd0;
      end else if (!idle_en) begin
         k_a <= 0; k_b <= 0;
         exp_a <= 11'd0; exp_b <= 11'd0;
      end else begin
         exp_a <= model_out(k_a, 16, 4, mvid_lsb, maud_lsb);
         exp_b <= model_out(k_b, 5, 1, mvid_lsb, maud_lsb);
         k_a <= k_a + 1;
         k_b <= k_b + 1;
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         checks = checks + 2;
         if ({sym_a, flag_a, bs_a, sr_a} !== exp_a) begin
            errors = errors + 1;
            $display("FAIL model_a t=%0t got sym=%h flag=%b bs=%b sr=%b expected %h/%b/%b/%b",
                     $time, sym_a, flag_a, bs_a, sr_a, exp_a[10:3], exp_a[2], exp_a[1], exp_a[0]);
         end
         if ({sym_b, flag_b, bs_b, sr_b} !== exp_b) begin
            errors = errors + 1;
            $display("FAIL model_b t=%0t got sym=%h flag=%b bs=%b sr=%b expected %h/%b/%b/%b",
                     $time, sym_b, flag_b, bs_b, sr_b, exp_b[10:3], exp_b[2], exp_b[1], exp_b[0]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic lit(input string name, input logic [10:0] got, input logic [10:0] want);
      checks = checks + 1;
      if (got !== want) begin
         errors = errors + 1;
         $display("FAIL %s got sym=%h flag=%b bs=%b sr=%b expected %h/%b/%b/%b", name,
                  got[10:3], got[2], got[1], got[0], want[10:3], want[2], want[1], want[0]);
      end
   endtask

   initial begin
      rst_n    = 1'b0;
      idle_en  = 1'b0;
      mvid_lsb = 8'h00;
      maud_lsb = 8'h00;
      tick();
      chk_en = 1'b1;
      tick();
      rst_n = 1'b1;

      // Disabled: outputs stay quiet.
      repeat (4) tick();
      lit("idle_off_a", {sym_a, flag_a, bs_a, sr_a}, {8'h00, 3'b000});
      lit("idle_off_b", {sym_b, flag_b, bs_b, sr_b}, {8'h00, 3'b000});

      // Five periods of dut_a: SR, BS, BS, BS, SR; dut_b restarts with SR every 5 cycles.
      idle_en = 1'b1;
      for (int t = 0; t < 80; t++) begin
         tick();
         case (t)
            0:  lit("start_sr",   {sym_a, flag_a, bs_a, sr_a}, {8'h1C, 3'b111});
            1:  lit("vbid",       {sym_a, flag_a, bs_a, sr_a}, {8'h09, 3'b000});
            2:  lit("mvid_zero",  {sym_a, flag_a, bs_a, sr_a}, {8'h00, 3'b000});
            3:  lit("maud_zero",  {sym_a, flag_a, bs_a, sr_a}, {8'h00, 3'b000});
            15: lit("last_dummy", {sym_a, flag_a, bs_a, sr_a}, {8'h00, 3'b000});
            16: lit("bs_p1",      {sym_a, flag_a, bs_a, sr_a}, {8'hBC, 3'b110});
            32: lit("bs_p2",      {sym_a, flag_a, bs_a, sr_a}, {8'hBC, 3'b110});
            48: lit("bs_p3",      {sym_a, flag_a, bs_a, sr_a}, {8'hBC, 3'b110});
            64: lit("sr_p4",      {sym_a, flag_a, bs_a, sr_a}, {8'h1C, 3'b111});
            default: ;
         endcase
         if (t == 4) lit("b_dummy", {sym_b, flag_b, bs_b, sr_b}, {8'h00, 3'b000});
         if (t == 5) lit("b_sr_p1", {sym_b, flag_b, bs_b, sr_b}, {8'h1C, 3'b111});
         if (t == 6) lit("b_vbid",  {sym_b, flag_b, bs_b, sr_b}, {8'h09, 3'b000});
      end

      // Mvid/Maud values land in slots 2 and 3 after a fresh enable.
      idle_en = 1'b0;
      tick();
      lit("drop_a", {sym_a, flag_a, bs_a, sr_a}, {8'h00, 3'b000});
      mvid_lsb = 8'hA5;
      maud_lsb = 8'h3C;
      idle_en  = 1'b1;
      for (int t = 0; t < 39; t++) begin
         tick();
         if (t == 0) lit("re_sr",   {sym_a, flag_a, bs_a, sr_a}, {8'h1C, 3'b111});
         if (t == 2) lit("mvid_a5", {sym_a, flag_a, bs_a, sr_a}, {8'hA5, 3'b000});
         if (t == 3) lit("maud_3c", {sym_a, flag_a, bs_a, sr_a}, {8'h3C, 3'b000});
         if (t == 7) lit("b_mvid",  {sym_b, flag_b, bs_b, sr_b}, {8'hA5, 3'b000});
      end

      // sym_cnt is now 7 in period 2: abort, hold off 3 cycles, restart with SR.
      idle_en = 1'b0;
      tick();
      lit("abort", {sym_a, flag_a, bs_a, sr_a}, {8'h00, 3'b000});
      tick();
      tick();
      idle_en = 1'b1;
      tick();
      lit("restart_sr", {sym_a, flag_a, bs_a, sr_a}, {8'h1C, 3'b111});

      // Asynchronous reset mid-stream.
      repeat (19) tick();
      rst_n = 1'b0;
      #1;
      lit("async_rst_a", {sym_a, flag_a, bs_a, sr_a}, {8'h00, 3'b000});
      lit("async_rst_b", {sym_b, flag_b, bs_b, sr_b}, {8'h00, 3'b000});
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      lit("post_rst_sr", {sym_a, flag_a, bs_a, sr_a}, {8'h1C, 3'b111});
      repeat (20) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
